// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_queue (with package ifetch_queue_pkg)
//  Description : Instruction-fetch front end. Keeps the ibus busy with
//                back-to-back requests and buffers the returned instructions
//                in a DEPTH-entry FIFO. Decode drains the FIFO through a
//                valid/ready handshake. A redirect flushes the FIFO and
//                restarts fetch. If a request is still in flight when the
//                redirect arrives, that response is discarded when it returns.
//  Revision    : 1.0 - initial release
// ============================================================================

package ifetch_queue_pkg;

    // Instruction bus request. valid and addr are held stable until data_ok.
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    // Instruction bus response. data is meaningful only while data_ok is high.
    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage : ifetch_queue_pkg

module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output ibus_req_t                ireq,
    input  ibus_resp_t               iresp,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   out_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    // The occupancy lookahead is one bit wider than the counter, so count+1
    // can never wrap before it is compared against DEPTH.
    localparam logic [c_cnt_w:0]   c_depth_lvl = (c_cnt_w + 1)'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

    // ------------------------------------------------------------------------
    // Request FSM encoding
    //   S_IDLE : nothing outstanding on the ibus
    //   S_REQ  : request outstanding; its response is pushed into the FIFO
    //   S_DROP : request outstanding; it was overtaken by a redirect, so its
    //            response is discarded
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [63:0]        r_fetch_pc;
    logic [63:0]        r_req_addr;
    logic [63:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic               w_req_valid;
    logic               w_complete;
    logic               w_push;
    logic               w_pop;
    logic               w_slot_free;
    logic               w_has_room;
    logic               w_issue;
    logic [63:0]        w_redirect_pc;
    logic [63:0]        w_target_pc;
    logic [c_cnt_w:0]   w_level;
    logic               w_unused_pc_lsbs;

    // Redirect targets are word aligned, so the two low bits are ignored.
    assign w_unused_pc_lsbs = ^redirect_pc[1:0];
    assign w_redirect_pc    = {redirect_pc[63:2], 2'b00};

    assign w_req_valid = (r_state != S_IDLE);

    // data_ok counts only while a request is actually on the bus.
    assign w_complete  = w_req_valid & iresp.data_ok;

    // Only a response that belongs to the current fetch stream is kept. A
    // response that arrives in the same cycle as a redirect is stale.
    assign w_push      = w_complete & (r_state == S_REQ) & ~redirect_valid;

    // A redirect overrides decode's pop; the whole FIFO is discarded anyway.
    assign w_pop       = out_valid & out_ready & ~redirect_valid;

    // The bus slot is free when idle or when the current request finishes now.
    assign w_slot_free = ~w_req_valid | w_complete;

    // Occupancy next cycle. An issued request must have a guaranteed slot, so
    // issue only when this lookahead is still below DEPTH. That is what makes
    // a push into a full FIFO impossible.
    assign w_level     = redirect_valid ? '0
                       : ({1'b0, r_count} + (c_cnt_w + 1)'(w_push))
                         - (c_cnt_w + 1)'(w_pop);
    assign w_has_room  = (w_level < c_depth_lvl);

    assign w_issue     = w_slot_free & w_has_room;

    // The address issued next: the redirect target takes precedence.
    assign w_target_pc = redirect_valid ? w_redirect_pc : r_fetch_pc;

    // ------------------------------------------------------------------------
    // Request FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the request FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_complete) begin
                    w_state_next = w_issue ? S_REQ : S_IDLE;
                end else if (redirect_valid) begin
                    // The request cannot be withdrawn, so remember to drop it.
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                // Further redirects only move the fetch PC. The single
                // outstanding response is still the only one to discard.
                if (w_complete) begin
                    w_state_next = w_issue ? S_REQ : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request address register: loaded only on issue, otherwise held stable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_addr <= '0;
        end else if (w_issue) begin
            r_req_addr <= w_target_pc;
        end
    end

    assign ireq = {w_req_valid, r_req_addr};

    // Fetch PC: steps by one word per issue and jumps on redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_issue) begin
            r_fetch_pc <= w_target_pc + 64'd4;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------

    // FIFO storage: written with the address of the completing request
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_req_addr;
            r_mem_instr[r_wr_ptr] <= iresp.data;
        end
    end

    // FIFO pointers and exact occupancy. Pointers wrap because DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation: the outputs read zero while the FIFO is empty.
    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]    : 64'd0;
    assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign out_count = r_count;

endmodule : ifetch_queue

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_queue
//  Description : Self-checking bench for ifetch_queue. It uses a behavioural
//                ibus memory with configurable latency and a queue-based
//                reference model of the fetch stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  out_count;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_count      (out_count)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural memory: answers after mem_lat wait cycles, data = addr ^ salt
    int          mem_lat  = 0;
    int          wcnt     = 0;
    bit          rand_lat = 0;
    logic [31:0] salt     = 32'h0;

    // Reference model of the architectural fetch state
    bit          m_valid = 0;
    bit          m_drop  = 0;
    logic [63:0] m_addr  = 64'h0;
    logic [63:0] m_pc    = RESET_PC;
    logic [63:0] mq_pc[$];
    logic [31:0] mq_ins[$];

    // Drive one cycle of inputs, advance the model and memory, move to next cycle
    task automatic step(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
        bit          ok, complete, push, pop, slot_free, issue;
        logic [63:0] tgt;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        ok             = (ireq.valid === 1'b1) && (wcnt >= mem_lat);
        iresp.data_ok  = ok;
        iresp.data     = ok ? (ireq.addr[31:0] ^ salt) : $urandom;

        complete = m_valid && ok;
        if (rst) begin
            m_valid = 0; m_drop = 0; m_addr = 64'h0; m_pc = RESET_PC;
            mq_pc.delete(); mq_ins.delete();
        end else begin
            push = complete && !m_drop && !rv;
            pop  = (mq_pc.size() > 0) && rdy && !rv;
            if (rv) begin
                mq_pc.delete(); mq_ins.delete();
            end else begin
                if (pop) begin
                    void'(mq_pc.pop_front()); void'(mq_ins.pop_front());
                end
                if (push) begin
                    mq_pc.push_back(m_addr); mq_ins.push_back(iresp.data);
                end
            end
            tgt       = rv ? {rpc[63:2], 2'b00} : m_pc;
            slot_free = !m_valid || complete;
            issue     = slot_free && (mq_pc.size() < DEPTH);
            if (complete)           m_drop = 0;
            else if (rv && m_valid) m_drop = 1;
            if (issue) begin
                m_valid = 1; m_addr = tgt; m_pc = tgt + 64'd4;
            end else begin
                if (complete) m_valid = 0;
                m_pc = tgt;
            end
        end

        if (rst || ireq.valid !== 1'b1 || ok) wcnt = 0;
        else                                  wcnt++;
        if (ok && rand_lat) mem_lat = $urandom_range(0, 3);

        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_lat = 0; rand_lat = 0; salt = 32'h0;
        step(1, 0, 64'h0, 0);
        step(1, 0, 64'h0, 0);
        checks += 6;
        if (ireq.valid !== 1'b0) begin failures++; $display("FAIL reset_ireq_valid got=%0b exp=0", ireq.valid); end
        if (ireq.addr !== 64'h0) begin failures++; $display("FAIL reset_ireq_addr got=%h exp=0", ireq.addr); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (out_count !== 3'd0)  begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        if (out_pc !== 64'h0)    begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    endtask

    task automatic test_stream();
        logic [63:0] ea, ep;
        mem_lat = 0; rand_lat = 0; salt = 32'h0;
        step(1, 0, 64'h0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 64'h0, 1);
            ea = RESET_PC + 64'(4 * i);
            checks += 2;
            if (ireq.valid !== 1'b1) begin failures++; $display("FAIL stream_valid cyc=%0d got=%0b exp=1", i, ireq.valid); end
            if (ireq.addr !== ea)    begin failures++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", i, ireq.addr, ea); end
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%0b exp=0", out_valid); end
            end else begin
                ep = RESET_PC + 64'(4 * (i - 1));
                checks += 4;
                if (out_valid !== 1'b1)        begin failures++; $display("FAIL stream_out_valid cyc=%0d got=%0b exp=1", i, out_valid); end
                if (out_pc !== ep)             begin failures++; $display("FAIL stream_out_pc cyc=%0d got=%h exp=%h", i, out_pc, ep); end
                if (out_instr !== ep[31:0])    begin failures++; $display("FAIL stream_out_instr cyc=%0d got=%h exp=%h", i, out_instr, ep[31:0]); end
                if (out_count !== 3'd1)        begin failures++; $display("FAIL stream_count cyc=%0d got=%0d exp=1", i, out_count); end
            end
        end
    endtask

    task automatic test_fill();
        int issued = 0;
        mem_lat = 0; rand_lat = 0; salt = 32'h0;
        step(1, 0, 64'h0, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 64'h0, 0);
            if (ireq.valid === 1'b1) issued++;
        end
        checks += 4;
        if (issued != 4)           begin failures++; $display("FAIL fill_issued got=%0d exp=4", issued); end
        if (out_count !== 3'd4)    begin failures++; $display("FAIL fill_count got=%0d exp=4", out_count); end
        if (ireq.valid !== 1'b0)   begin failures++; $display("FAIL fill_idle got=%0b exp=0", ireq.valid); end
        if (out_pc !== RESET_PC)   begin failures++; $display("FAIL fill_head got=%h exp=%h", out_pc, RESET_PC); end
        step(0, 0, 64'h0, 1);
        checks += 3;
        if (ireq.valid !== 1'b1)                 begin failures++; $display("FAIL fill_reissue_valid got=%0b exp=1", ireq.valid); end
        if (ireq.addr !== RESET_PC + 64'h10)     begin failures++; $display("FAIL fill_reissue_addr got=%h exp=%h", ireq.addr, RESET_PC + 64'h10); end
        if (out_count !== 3'd3)                  begin failures++; $display("FAIL fill_pop_count got=%0d exp=3", out_count); end
        issued = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 64'h0, 0);
            if (ireq.valid === 1'b1) issued++;
        end
        checks += 3;
        if (issued != 0)                     begin failures++; $display("FAIL fill_extra_issue got=%0d exp=0", issued); end
        if (out_count !== 3'd4)              begin failures++; $display("FAIL fill_refull got=%0d exp=4", out_count); end
        if (out_pc !== RESET_PC + 64'h4)     begin failures++; $display("FAIL fill_new_head got=%h exp=%h", out_pc, RESET_PC + 64'h4); end
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        mem_lat = 3; rand_lat = 0; salt = 32'h0;
        step(1, 0, 64'h0, 1);
        for (int k = 0; k < 40 && !found; k++) begin
            step(0, 0, 64'h0, 1);
            if (ireq.valid === 1'b1 && ireq.addr === RESET_PC + 64'h8) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL inflight_reach got=timeout exp=addr %h", RESET_PC + 64'h8); end
        step(0, 0, 64'h0, 1);
        step(0, 1, 64'h8000_1002, 1);
        checks += 3;
        if (ireq.addr !== RESET_PC + 64'h8) begin failures++; $display("FAIL inflight_hold got=%h exp=%h", ireq.addr, RESET_PC + 64'h8); end
        if (out_valid !== 1'b0)             begin failures++; $display("FAIL inflight_flush got=%0b exp=0", out_valid); end
        if (out_count !== 3'd0)             begin failures++; $display("FAIL inflight_count got=%0d exp=0", out_count); end
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 64'h0, 1);
            if (ireq.valid === 1'b1 && ireq.addr === 64'h8000_1000) begin
                found = 1;
            end else begin
                checks += 2;
                if (ireq.valid !== 1'b1 || ireq.addr !== RESET_PC + 64'h8) begin
                    failures++; $display("FAIL inflight_stable got=%0b/%h exp=1/%h", ireq.valid, ireq.addr, RESET_PC + 64'h8);
                end
                if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_stale_out got=%h exp=none", out_pc); end
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL inflight_next_req got=timeout exp=80001000"); end
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 64'h0, 1);
            if (out_valid === 1'b1) found = 1;
        end
        checks += 2;
        if (!found || out_pc !== 64'h8000_1000) begin failures++; $display("FAIL inflight_first_out got=%0b/%h exp=1/80001000", found, out_pc); end
        if (out_instr !== 32'h8000_1000)        begin failures++; $display("FAIL inflight_first_instr got=%h exp=80001000", out_instr); end
    endtask

    task automatic test_redirect_dataok();
        mem_lat = 0; rand_lat = 0; salt = 32'h0;
        step(1, 0, 64'h0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 64'h0, 0);
        checks++;
        if (out_count !== 3'd2) begin failures++; $display("FAIL same_pre_count got=%0d exp=2", out_count); end
        step(0, 1, 64'h8000_4001, 1);
        checks += 4;
        if (out_count !== 3'd0)           begin failures++; $display("FAIL same_count got=%0d exp=0", out_count); end
        if (out_valid !== 1'b0)           begin failures++; $display("FAIL same_valid got=%0b exp=0", out_valid); end
        if (ireq.valid !== 1'b1)          begin failures++; $display("FAIL same_req_valid got=%0b exp=1", ireq.valid); end
        if (ireq.addr !== 64'h8000_4000)  begin failures++; $display("FAIL same_req_addr got=%h exp=80004000", ireq.addr); end
        step(0, 0, 64'h0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8000_4000) begin
            failures++; $display("FAIL same_first_out got=%0b/%h exp=1/80004000", out_valid, out_pc);
        end
    endtask

    task automatic test_double_redirect();
        bit found = 0;
        mem_lat = 3; rand_lat = 0; salt = 32'h0;
        step(1, 0, 64'h0, 1);
        step(0, 0, 64'h0, 1);
        step(0, 1, 64'h8000_2000, 1);
        step(0, 1, 64'h8000_3000, 1);
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 64'h0, 1);
            if (ireq.addr !== RESET_PC) found = 1;
        end
        checks += 2;
        if (!found)                       begin failures++; $display("FAIL dbl_release got=timeout exp=new request"); end
        if (ireq.addr !== 64'h8000_3000)  begin failures++; $display("FAIL dbl_next_addr got=%h exp=80003000", ireq.addr); end
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 64'h0, 1);
            if (out_valid === 1'b1) found = 1;
        end
        checks++;
        if (!found || out_pc !== 64'h8000_3000) begin failures++; $display("FAIL dbl_first_out got=%0b/%h exp=1/80003000", found, out_pc); end
    endtask

    task automatic test_reset_midreq();
        mem_lat = 0; rand_lat = 0; salt = 32'h0;
        step(1, 0, 64'h0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 64'h0, 0);
        checks++;
        if (ireq.valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%0b exp=1", ireq.valid); end
        step(1, 0, 64'h0, 0);
        checks += 3;
        if (out_count !== 3'd0)  begin failures++; $display("FAIL rstmid_count got=%0d exp=0", out_count); end
        if (ireq.valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", ireq.valid); end
        if (ireq.addr !== 64'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", ireq.addr); end
        step(0, 0, 64'h0, 0);
        checks += 2;
        if (ireq.valid !== 1'b1 || ireq.addr !== RESET_PC) begin failures++; $display("FAIL rstmid_first_req got=%0b/%h exp=1/%h", ireq.valid, ireq.addr, RESET_PC); end
        if (out_count !== 3'd0) begin failures++; $display("FAIL rstmid_stale got=%0d exp=0", out_count); end
        step(0, 0, 64'h0, 0);
        checks += 2;
        if (out_count !== 3'd1) begin failures++; $display("FAIL rstmid_push_count got=%0d exp=1", out_count); end
        if (out_pc !== RESET_PC || out_instr !== RESET_PC[31:0]) begin
            failures++; $display("FAIL rstmid_head got=%h/%h exp=%h/%h", out_pc, out_instr, RESET_PC, RESET_PC[31:0]);
        end
    endtask

    task automatic test_random();
        bit          rst, rv, rdy, ev;
        logic [63:0] rpc, epc;
        logic [31:0] eins;
        salt = $urandom; rand_lat = 1; mem_lat = $urandom_range(0, 3);
        step(1, 0, 64'h0, 0);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else                           rpc = 64'h8000_0000 | 64'($urandom_range(0, 65535));
            step(rst, rv, rpc, rdy);
            ev   = (mq_pc.size() > 0);
            epc  = ev ? mq_pc[0]  : 64'h0;
            eins = ev ? mq_ins[0] : 32'h0;
            checks += 7;
            if (ireq.valid !== m_valid) begin failures++; $display("FAIL rnd_req_valid n=%0d got=%0b exp=%0b", n, ireq.valid, m_valid); end
            if (ireq.addr !== m_addr)   begin failures++; $display("FAIL rnd_req_addr n=%0d got=%h exp=%h", n, ireq.addr, m_addr); end
            if (out_valid !== ev)       begin failures++; $display("FAIL rnd_out_valid n=%0d got=%0b exp=%0b", n, out_valid, ev); end
            if (out_count !== 3'(mq_pc.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, out_count, mq_pc.size()); end
            if (out_pc !== epc)         begin failures++; $display("FAIL rnd_out_pc n=%0d got=%h exp=%h", n, out_pc, epc); end
            if (out_instr !== eins)     begin failures++; $display("FAIL rnd_out_instr n=%0d got=%h exp=%h", n, out_instr, eins); end
            if (out_count > 3'(DEPTH))  begin failures++; $display("FAIL rnd_overflow n=%0d got=%0d exp<=%0d", n, out_count, DEPTH); end
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
        iresp = '0;
        #1;
        test_reset();
        test_stream();
        test_fill();
        test_redirect_inflight();
        test_redirect_dataok();
        test_double_redirect();
        test_reset_midreq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_ifetch_queue

`default_nettype wire
